// File: rtl/mult_sequencer.sv
// Sequencer between control and the iterative multiplier: drives the multiplier's
// State code, waits for its done flag, captures the product into Hi/Lo and handles MTHI/MTLO.
module mult_sequencer #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        MultDone,
  input  logic [31:0] MultHi,
  input  logic [31:0] MultLo,
  input  logic        WriteHi,
  input  logic        WriteLo,
  input  logic [31:0] WriteData,
  output logic [1:0]  MultState,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] MS_NEUTRAL = 2'b00;
  localparam logic [1:0] MS_LOAD    = 2'b01;
  localparam logic [1:0] MS_RUN     = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             wr_ok;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    MultState = MS_NEUTRAL;
    Busy      = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;

    // Software writes land only while the multiplier datapath is not in use.
    wr_ok = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    if (wr_ok && WriteHi) hi_d = WriteData;
    if (wr_ok && WriteLo) lo_d = WriteData;

    unique case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_LOAD;
      end
      S_LOAD: begin
        MultState = MS_LOAD;
        Busy      = 1'b1;
        cnt_d     = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        MultState = MS_RUN;
        Busy      = 1'b1;
        if (MultDone)               state_d = S_CAPTURE;
        else if (cnt_q == CNT_LAST) state_d = S_ERR;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      S_CAPTURE: begin
        // State stays at RUN so the multiplier keeps the product stable while it is sampled.
        MultState = MS_RUN;
        Busy      = 1'b1;
        hi_d      = MultHi;
        lo_d      = MultLo;
        state_d   = S_DONE;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        Error = 1'b1;
        if (Start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Hi = hi_q;
  assign Lo = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural multiplier with programmable iteration count,
// a transaction-level reference for Hi/Lo/Error and per-cycle timing expectations.
module tb_mult_sequencer;

  localparam int MAX_CYCLES = 40;

  logic        Clock = 1'b0;
  logic        Reset, Start, MultDone, WriteHi, WriteLo;
  logic [31:0] MultHi, MultLo, WriteData, Hi, Lo;
  logic [1:0]  MultState;
  logic        Busy, Done, Error;

  mult_sequencer #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MultDone(MultDone),
    .MultHi(MultHi), .MultLo(MultLo), .WriteHi(WriteHi), .WriteLo(WriteLo),
    .WriteData(WriteData), .MultState(MultState), .Busy(Busy), .Done(Done),
    .Error(Error), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Multiplier model: loads on State 01, counts mul_n iterations in State 10, then raises done.
  logic [31:0] op_a = '0, op_b = '0;
  int          mul_n = 32;
  int          mul_cnt = 0;
  logic        mul_done = 1'b0;
  logic        force_done = 1'b0;
  logic [63:0] prod;

  assign prod     = 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
  assign MultDone = mul_done | force_done;
  assign MultHi   = mul_done ? prod[63:32] : 32'hA5A5_A5A5;
  assign MultLo   = mul_done ? prod[31:0]  : 32'h5A5A_5A5A;

  always @(posedge Clock) begin
    case (MultState)
      2'b01: begin mul_cnt <= 0; mul_done <= 1'b0; end
      2'b10: if (!mul_done) begin
        mul_cnt <= mul_cnt + 1;
        if (mul_cnt + 1 == mul_n) mul_done <= 1'b1;
      end
      default: begin mul_cnt <= 0; mul_done <= 1'b0; end
    endcase
  end

  logic [31:0] ref_hi = '0, ref_lo = '0;
  logic        ref_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task step;
    @(posedge Clock);
    #1;
  endtask

  function automatic int last_busy_cycle(input int n);
    return (n <= MAX_CYCLES - 1) ? n + 3 : MAX_CYCLES + 1;
  endfunction

  // One multiply: Start in cycle 0; LOAD cycle 1; RUN cycles 2..n+2; CAPTURE n+3; DONE n+4.
  // Timeout: RUN cycles 2..MAX_CYCLES+1, ERR from cycle MAX_CYCLES+2.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int n, input int extra_start, input int busy_wr,
                        input logic same_edge_wr, input logic [31:0] wr_data);
    int   last_busy, end_cyc, n_done, first_done, first_err, bad_ms, bad_busy;
    logic completes;
    logic [1:0]  exp_ms;
    logic [63:0] exp_p;
    completes = (n <= MAX_CYCLES - 1);
    last_busy = last_busy_cycle(n);
    end_cyc   = completes ? n + 5 : MAX_CYCLES + 3;
    exp_p     = 64'(longint'($signed(a)) * longint'($signed(b)));
    op_a = a; op_b = b; mul_n = n;
    Start = 1'b1;
    if (same_edge_wr) begin
      WriteHi = 1'b1; WriteLo = 1'b1; WriteData = wr_data;
      ref_hi = wr_data; ref_lo = wr_data;
    end
    step;
    Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    if (same_edge_wr) check({tag, "_same_edge_wr"}, {Hi, Lo}, {wr_data, wr_data});
    check({tag, "_err_clear"}, {63'd0, Error}, 64'd0);
    n_done = 0; first_done = -1; first_err = -1; bad_ms = 0; bad_busy = 0;
    for (int c = 1; c <= end_cyc; c++) begin
      exp_ms = (c == 1) ? 2'b01 : (c <= last_busy) ? 2'b10 : 2'b00;
      if (MultState !== exp_ms) bad_ms++;
      if (Busy !== (c <= last_busy)) bad_busy++;
      if (Done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (Error === 1'b1 && first_err < 0) first_err = c;
      Start     = (c == extra_start);
      WriteHi   = (c == busy_wr);
      WriteLo   = (c == busy_wr);
      WriteData = 32'h0BAD_0000 ^ 32'(c);
      if (c < end_cyc) step;
    end
    Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    if (completes) begin
      ref_hi = exp_p[63:32]; ref_lo = exp_p[31:0]; ref_err = 1'b0;
    end else begin
      ref_err = 1'b1;
    end
    check({tag, "_mstate_seq"}, 64'(bad_ms), 64'd0);
    check({tag, "_busy_seq"}, 64'(bad_busy), 64'd0);
    check({tag, "_done_count"}, 64'(n_done), completes ? 64'd1 : 64'd0);
    check({tag, "_done_cycle"}, 64'(first_done), completes ? 64'(n + 4) : 64'(-1));
    check({tag, "_err_cycle"}, 64'(first_err), completes ? 64'(-1) : 64'(MAX_CYCLES + 2));
    check({tag, "_hi"}, {32'd0, Hi}, {32'd0, ref_hi});
    check({tag, "_lo"}, {32'd0, Lo}, {32'd0, ref_lo});
    check({tag, "_error"}, {63'd0, Error}, {63'd0, ref_err});
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a, b;
    int          n, extra_start, busy_wr;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int done_seen;
    vecs[0] = '{"mul_7xm3",   32'd7,       32'hFFFF_FFFD, 32, 0,  0,  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{"mul_7x5_rs", 32'd7,       32'd5,         32, 10, 5,  32'd0,         32'd35,        1'b0};
    vecs[2] = '{"mul_m1xm1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 3,  0,  32'd0,         32'd1,         1'b0};
    vecs[3] = '{"mul_n39",    32'h0001_0000, 32'h0001_0000, 39, 0, 41, 32'd1,         32'd0,         1'b0};
    vecs[4] = '{"timeout",    32'd9,       32'd9,         40, 0,  20, 32'd1,         32'd0,         1'b1};
    vecs[5] = '{"after_err",  32'd3,       32'd4,         1,  2,  2,  32'd0,         32'd12,        1'b0};

    Reset = 1'b0; Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;
    step; step;
    check("rst_hi", {32'd0, Hi}, 64'd0);
    check("rst_lo", {32'd0, Lo}, 64'd0);
    check("rst_out", {58'd0, MultState, Busy, Done, Error}, 64'd0);
    Reset = 1'b1;
    step;

    WriteHi = 1'b1; WriteData = 32'hDEAD_BEEF; step; WriteHi = 1'b0;
    ref_hi = 32'hDEAD_BEEF;
    check("mthi", {Hi, Lo}, {ref_hi, ref_lo});
    WriteLo = 1'b1; WriteData = 32'h1234_5678; step; WriteLo = 1'b0;
    ref_lo = 32'h1234_5678;
    check("mtlo", {Hi, Lo}, {ref_hi, ref_lo});
    WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hCAFE_F00D; step;
    WriteHi = 1'b0; WriteLo = 1'b0;
    ref_hi = 32'hCAFE_F00D; ref_lo = 32'hCAFE_F00D;
    check("mthi_mtlo", {Hi, Lo}, {ref_hi, ref_lo});

    force_done = 1'b1;
    step; step; step;
    check("stale_done_idle", {61'd0, MultState, Busy, Done}, 64'd0);
    force_done = 1'b0;
    step;

    foreach (vecs[i]) begin
      run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].n,
             vecs[i].extra_start, vecs[i].busy_wr, 1'b0, 32'd0);
      check({vecs[i].tag, "_tbl"}, {Hi, Lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      check({vecs[i].tag, "_tbl_err"}, {63'd0, Error}, {63'd0, vecs[i].exp_err});
    end

    run_op("same_edge", 32'd6, 32'd7, 3, 0, 0, 1'b1, 32'h1111_2222);
    check("same_edge_tbl", {Hi, Lo}, {32'd0, 32'd42});

    for (int k = 0; k < 16; k++) begin
      int n, lb, xs, bw;
      logic [31:0] d;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        WriteHi = 1'($urandom_range(0, 1));
        WriteLo = 1'($urandom_range(0, 1));
        WriteData = d;
        if (WriteHi) ref_hi = d;
        if (WriteLo) ref_lo = d;
        step;
        WriteHi = 1'b0; WriteLo = 1'b0;
        check("rnd_wr", {Hi, Lo}, {ref_hi, ref_lo});
      end
      n  = $urandom_range(1, MAX_CYCLES + 4);
      lb = last_busy_cycle(n);
      xs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lb) : 0;
      bw = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lb) : 0;
      run_op("rnd", $urandom, $urandom, n, xs, bw, 1'b0, 32'd0);
    end

    if (Error) begin
      run_op("leave_err", 32'd2, 32'd21, 4, 0, 0, 1'b0, 32'd0);
    end
    op_a = 32'd7; op_b = 32'd5; mul_n = 32;
    Start = 1'b1; step; Start = 1'b0;
    repeat (11) step;
    Reset = 1'b0; step; Reset = 1'b1;
    ref_hi = '0; ref_lo = '0; ref_err = 1'b0;
    check("midrun_rst_ms", {62'd0, MultState}, 64'd0);
    check("midrun_rst_hilo", {Hi, Lo}, 64'd0);
    check("midrun_rst_flags", {61'd0, Busy, Done, Error}, 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step;
      if (Done === 1'b1 || MultState !== 2'b00) done_seen++;
    end
    check("midrun_rst_quiet", 64'(done_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Sits between the main control unit and the multiplier. Converts a one-cycle Start pulse into the multiplier's 2-bit State sequence (00 neutral, 01 load, 10 run) and waits for the multiplier's done flag.
- Captures the 64-bit product into architectural Hi/Lo registers and returns a one-cycle Done pulse to control.
- Also owns MTHI/MTLO writes and a run-timeout error.

Parameters:
- MAX_CYCLES, 40, maximum RUN-state cycles before the error path is taken; must be >= 34.
- CNT_W, 6, width of the RUN cycle counter; must hold MAX_CYCLES.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle request from control to run MULT; operands already on the multiplier inputs.
- MultDone  in  1  done flag from the multiplier.
- MultHi  in  32  multiplier product high word.
- MultLo  in  32  multiplier product low word.
- WriteHi  in  1  MTHI strobe.
- WriteLo  in  1  MTLO strobe.
- WriteData  in  32  data for MTHI/MTLO.
- MultState  out  2  State code driven to the multiplier.
- Busy  out  1  high in LOAD, RUN, CAPTURE.
- Done  out  1  one-cycle pulse when Hi/Lo are updated.
- Error  out  1  sticky timeout flag.
- Hi  out  32  architectural Hi register.
- Lo  out  32  architectural Lo register.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - State goes to IDLE.
  - Hi=0, Lo=0, Done=0, Error=0, Busy=0, MultState=00, counter=0.
  - Overrides every other input, including mid-operation.
- Outputs are decoded from the registered FSM state:
  - IDLE: MultState=00, Busy=0, Done=0.
  - LOAD: MultState=01, Busy=1.
  - RUN: MultState=10, Busy=1.
  - CAPTURE: MultState=10, Busy=1.
  - DONE: MultState=00, Busy=0, Done=1.
  - ERR: MultState=00, Busy=0, Error=1.
- Transitions:
  - IDLE -> LOAD on Start==1.
  - LOAD -> RUN unconditionally after 1 cycle; counter cleared.
  - RUN -> CAPTURE when MultDone==1 is sampled; otherwise counter+1.
  - RUN -> ERR when counter==MAX_CYCLES-1 and MultDone==0.
  - CAPTURE -> DONE: Hi<=MultHi and Lo<=MultLo on the edge leaving CAPTURE. MultState is held at 10 through CAPTURE so the product stays stable.
  - DONE -> IDLE after 1 cycle.
  - ERR -> LOAD on Start==1 (Error clears on the same edge); otherwise stay in ERR.
- Latency: Done asserts exactly 2 cycles after the first edge that samples MultDone==1. With a 32-iteration multiplier, Start to Done is 36 cycles.
- Start received in any state other than IDLE or ERR is ignored; there is no queueing.
- WriteHi/WriteLo:
  - Accepted only in IDLE, DONE or ERR. Each strobe writes WriteData to its own register.
  - If both strobes are asserted, both registers are written.
  - Ignored while Busy=1.
- Same-edge Start and WriteHi/WriteLo in IDLE: the write takes effect and Start is also accepted. The later capture overwrites the written value.
- In ERR, Hi and Lo keep their previous values; the partial product is never captured.
- Reset mid-run: MultState returns to 00 next cycle, which parks the multiplier in neutral. No Done pulse is produced.
- MultDone is ignored outside RUN; a stale high in IDLE/LOAD has no effect.
- Counter wraps never, because the ERR exit bounds it.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> Hi=Lo=0, MultState=00, Busy=0, Done=0, Error=0.
- Multiplier model operands 7 and -3, Start pulse -> MultState goes 01 for 1 cycle, then 10. Done pulses once at cycle 36. Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
- Start pulsed again in RUN during the multiply 7 * 5 -> no restart, a single Done, Lo=32'd35, Hi=0.
- Hold MultDone=0 after Start -> ERR after 40 RUN cycles, Error=1, Hi/Lo unchanged. A following Start clears Error and enters LOAD.
- In IDLE, WriteHi=1 with WriteData=32'hDEADBEEF -> Hi=32'hDEADBEEF next cycle. The same strobe while Busy -> Hi unchanged.
- Reset=0 asserted 10 cycles into RUN -> next cycle MultState=00, Hi=Lo=0, no Done pulse.
